// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: state encoding, IF/ID entry type and constants shared by the fetch stage.
package if_fetch_unit_pkg;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry {pc, inst} holding register that catches a fetch returned while decode is stalled.
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  logic   i_drain,
    input  logic   i_flush,
    input  fetch_t i_data,
    output fetch_t o_data,
    output logic   o_buf_valid
);
    logic   r_valid;
    fetch_t r_data;
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end
    assign o_data      = r_data;
    assign o_buf_valid = r_valid;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, imem req/ack fetch, IF/ID register with stall skid buffer and redirect flush.
// Optional IF_MISALIGN_CHK_EN pulses o_misalign after a redirect whose target is not word aligned.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_inst,
    output logic        o_misalign
);
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic        r_if_id_valid;
    fetch_t      r_if_id;
    fetch_t      w_buf;
    logic        w_buf_valid;
    logic        w_fetch_xfer;
    logic        w_load;
    logic        w_drain;

    assign o_imem_req   = (r_state == S_DROP) || (r_state == S_FETCH && !w_buf_valid);
    assign o_imem_addr  = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign w_fetch_xfer = (r_state == S_FETCH) && o_imem_req && i_imem_ack;
    assign w_load       = !i_redirect_valid && w_fetch_xfer && i_stall;
    assign w_drain      = !i_redirect_valid && w_buf_valid && !i_stall;

    fetch_skid_buf u_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_drain     (w_drain),
        .i_flush     (i_redirect_valid),
        .i_data      ('{pc: r_pc, inst: i_imem_rdata}),
        .o_data      (w_buf),
        .o_buf_valid (w_buf_valid)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_drop_addr   <= RESET_PC;
            r_if_id_valid <= 1'b0;
            r_if_id       <= '{pc: 32'h0, inst: NOP};
        end else if (i_redirect_valid) begin
            r_if_id_valid <= 1'b0;
            r_pc          <= {i_redirect_pc[31:2], 2'b00};
            r_drop_addr   <= o_imem_addr;
            // an outstanding unacked request must still be completed and its data thrown away
            r_state       <= (o_imem_req && !i_imem_ack) ? S_DROP : S_FETCH;
        end else begin
            if (r_state == S_IDLE || (r_state == S_DROP && i_imem_ack))
                r_state <= S_FETCH;
            if (w_fetch_xfer)
                r_pc <= r_pc + 32'd4;
            if (!i_stall) begin
                r_if_id_valid <= w_buf_valid || w_fetch_xfer;
                if (w_buf_valid)
                    r_if_id <= w_buf;
                else if (w_fetch_xfer)
                    r_if_id <= '{pc: r_pc, inst: i_imem_rdata};
            end
        end
    end

    assign o_if_id_valid = r_if_id_valid;
    assign o_if_id_pc    = r_if_id.pc;
    assign o_if_id_inst  = r_if_id.inst;

`ifdef IF_MISALIGN_CHK_EN
    logic r_misalign;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_misalign <= 1'b0;
        else
            r_misalign <= i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    end
    assign o_misalign = r_misalign;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^i_redirect_pc[1:0];
    assign o_misalign   = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench; the consumed IF/ID stream must be the sequential program from each restart point.
module tb_if_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        ack = 1'b1;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] iinst;
    logic        mis;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   consumed = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_redirect_valid (redir),
        .i_redirect_pc    (rpc),
        .o_imem_req       (req),
        .o_imem_addr      (addr),
        .i_imem_ack       (ack),
        .i_imem_rdata     (rdata),
        .o_if_id_valid    (vld),
        .o_if_id_pc       (ipc),
        .o_if_id_inst     (iinst),
        .o_misalign       (mis)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign rdata = mem(addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic restart(input logic [31:0] a);
        q.delete();
        for (int i = 0; i < 64; i++)
            q.push_back('{pc: a + 32'(i * 4), inst: mem(a + 32'(i * 4))});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic        prev_pend = 1'b0;
    logic        prev_mis = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always @(negedge clk) begin
        chk("misalign", 32'(mis), 32'(prev_mis));
        if (prev_pend) begin
            chk("req_held", 32'(req), 32'd1);
            chk("addr_held", addr, prev_addr);
        end
        if (!rst && vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty: IF/ID pc %h valid with no expected entry", ipc);
            end else begin
                chk("if_id_pc", ipc, q[0].pc);
                chk("if_id_inst", iinst, q[0].inst);
                if (!stall && !redir) begin
                    void'(q.pop_front());
                    consumed++;
                end
            end
        end
        prev_pend = !rst && req && !ack;
        prev_addr = addr;
`ifdef IF_MISALIGN_CHK_EN
        prev_mis = !rst && redir && (rpc[1:0] != 2'b00);
`else
        prev_mis = 1'b0;
`endif
    end

    int          since;
    logic        pend;
    logic [31:0] paddr;

    initial begin
        restart(RST_PC);
        repeat (3) tick;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, RST_PC);
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_inst", iinst, NOP_W);
        chk("rst_misalign", 32'(mis), 32'd0);
        rst = 1'b0;
        tick;
        chk("zw_req", 32'(req), 32'd1);
        chk("zw_addr0", addr, 32'h0);
        tick;
        chk("zw_addr4", addr, 32'h4);
        chk("zw_valid", 32'(vld), 32'd1);
        chk("zw_pc0", ipc, 32'h0);
        tick;
        chk("zw_addr8", addr, 32'h8);
        chk("zw_pc4", ipc, 32'h4);
        stall = 1'b1;
        tick;
        chk("stall_req0", 32'(req), 32'd0);
        chk("stall_hold", ipc, 32'h4);
        tick;
        chk("stall_req0b", 32'(req), 32'd0);
        tick;
        chk("stall_hold2", ipc, 32'h4);
        stall = 1'b0;
        tick;
        chk("drain_pc8", ipc, 32'h8);
        chk("drain_req", 32'(req), 32'd1);
        chk("drain_addr", addr, 32'hC);
        tick;
        chk("after_drain", ipc, 32'hC);
        stall = 1'b1;
        redir = 1'b1;
        rpc   = 32'h80;
        tick;
        chk("rs_valid", 32'(vld), 32'd0);
        chk("rs_addr", addr, 32'h80);
        redir = 1'b0;
        stall = 1'b0;
        restart(32'h80);
        tick;
        chk("rs_pc", ipc, 32'h80);
        redir = 1'b1;
        rpc   = 32'h82;
        tick;
        chk("mis_addr", addr, 32'h80);
`ifdef IF_MISALIGN_CHK_EN
        chk("mis_pulse", 32'(mis), 32'd1);
`else
        chk("mis_pulse", 32'(mis), 32'd0);
`endif
        redir = 1'b0;
        restart(32'h80);
        tick;
        chk("mis_end", 32'(mis), 32'd0);
        chk("mis_pc", ipc, 32'h80);
        ack = 1'b0;
        tick;
        chk("drop_req", 32'(req), 32'd1);
        chk("drop_addr0", addr, 32'h84);
        redir = 1'b1;
        rpc   = 32'h100;
        tick;
        chk("drop_addr1", addr, 32'h84);
        chk("drop_valid", 32'(vld), 32'd0);
        redir = 1'b0;
        restart(32'h100);
        tick;
        chk("drop_addr2", addr, 32'h84);
        ack = 1'b1;
        tick;
        chk("drop_next", addr, 32'h100);
        chk("drop_valid2", 32'(vld), 32'd0);
        tick;
        chk("drop_pc", ipc, 32'h100);
        ack = 1'b0;
        tick;
        chk("pend_addr", addr, 32'h104);
        rst = 1'b1;
        tick;
        chk("abort_req", 32'(req), 32'd0);
        chk("abort_valid", 32'(vld), 32'd0);
        rst = 1'b0;
        ack = 1'b1;
        restart(RST_PC);
        tick;
        chk("abort_req1", 32'(req), 32'd1);
        chk("abort_addr", addr, RST_PC);

        since = 0;
        pend  = 1'b0;
        paddr = RST_PC;
        for (int c = 0; c < 4000; c++) begin
            tick;
            if (pend) begin
                restart(paddr);
                pend  = 1'b0;
                since = 0;
            end
            since++;
            redir = 1'b0;
            rst   = 1'b0;
            stall = $urandom_range(9) < 3;
            ack   = $urandom_range(9) < 6;
            if ($urandom_range(299) == 0) begin
                rst   = 1'b1;
                pend  = 1'b1;
                paddr = RST_PC;
            end else if (since >= 40 || $urandom_range(19) == 0) begin
                redir = 1'b1;
                rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
                pend  = 1'b1;
                paddr = {rpc[31:2], 2'b00};
            end
        end
        tick;
        redir = 1'b0;
        rst   = 1'b0;
        checks++;
        if (consumed < 300) begin
            errors++;
            $display("FAIL progress: consumed %0d instructions, required at least 300", consumed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the PC register, issues instruction-memory requests over a req/ack handshake, and fills the IF/ID pipeline register. It consumes the next-PC redirect produced by branch/jump resolution and absorbs stalls through a one-entry buffer, so a stall never loses or duplicates a fetched instruction.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold IF/ID (decode cannot accept)
- redirect_valid  in  1  taken branch/jump/jalr: flush and refetch
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request; held until acked
- imem_addr  out  32  fetch address; stable while imem_req=1 and not acked
- imem_ack  in  1  data valid this cycle; may coincide with the request cycle (zero-wait)
- imem_rdata  in  32  instruction word
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_pc  out  32  PC of the IF/ID instruction
- if_id_inst  out  32  IF/ID instruction
- misalign  out  1  one-cycle pulse on a misaligned redirect (see Configuration)

## Operation
- Transfer: imem_req && imem_ack.
- States: S_IDLE (reset), S_FETCH, S_DROP.
- S_IDLE: imem_req=0; next cycle goes to S_FETCH.
- S_FETCH: imem_req = !buf_valid; imem_addr = pc.
  - On transfer with stall=0 and buf_valid=0: IF/ID <= {pc, rdata}, valid=1; pc <= pc+4.
  - On transfer with stall=1: buf <= {pc, rdata}, buf_valid=1; pc <= pc+4.
- Buffer drain: when buf_valid && !stall, IF/ID <= buf and buf_valid <= 0. Requests resume the following cycle.
- Stall with no transfer: IF/ID holds.
- Redirect always has priority over stall and ack. Its effects:
  - if_id_valid <= 0, buf_valid <= 0, pc <= {redirect_pc[31:2], 2'b00}.
  - If imem_req=1 and imem_ack=0 this cycle, go to S_DROP and latch drop_addr = the current imem_addr.
  - Otherwise go to S_FETCH. Same-cycle ack data is discarded.
- S_DROP: imem_req=1, imem_addr=drop_addr.
  - On ack, discard the data and go to S_FETCH.
  - A further redirect in S_DROP updates pc and stays in S_DROP unless acked in the same cycle.
- pc arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - if_id_valid=0, if_id_pc=0, if_id_inst=32'h0000_0013 (NOP)
  - misalign=0, buf_valid=0, pc=RESET_PC, state S_IDLE
- Reset asserted mid-request aborts the request. The memory side must tolerate req dropping under reset.
- Zero-wait memory: imem_req rises the first cycle after rst deasserts. The IF/ID for that address is valid one cycle later. Throughput is one instruction per cycle.
- N-cycle ack: IF/ID is valid the cycle after ack.
- Redirect: the first request to the target is the next cycle; with a pending request it is the cycle after the dropped ack.
- imem_req and imem_addr are decoded from registered state only.

## Configuration
- IF_MISALIGN_CHK_EN defined: a redirect with redirect_pc[1:0]!=0 pulses misalign for one cycle. The pulse coincides with the first cycle after the redirect. The fetch proceeds from the aligned address.
- Not defined: low bits are dropped silently and misalign is tied to 0.

## Structure
- Shared package holds:
  - state encoding (S_IDLE/S_FETCH/S_DROP)
  - NOP constant 32'h0000_0013
  - default RESET_PC
- Sub-module fetch_skid_buf: one-entry {pc, inst} buffer with load/drain/flush inputs and a buf_valid output.

## Test plan
- Reset, RESET_PC=0, ack tied 1 → imem_addr 0,4,8 on consecutive cycles; if_id_pc=0 one cycle after first req; if_id_inst=NOP during reset.
- Ack of 0x8 while stall=1 for 3 cycles → buf_valid=1, imem_req=0; IF/ID holds 0x4; after release IF/ID=0x8, then 0xC; no gap or duplicate.
- Request 0x10 with ack delayed 3 cycles, redirect to 0x80 one cycle after req → S_DROP, imem_addr stays 0x10 until ack, data dropped; next req addr 0x80; if_id_valid=0 until 0x80 delivered.
- redirect_valid=1 and stall=1 in the same cycle with a valid IF/ID → if_id_valid=0 next cycle; next fetch 0x80.
- Redirect to 0x82 → imem_addr 0x80. With IF_MISALIGN_CHK_EN, misalign=1 for exactly one cycle; without it, misalign stays 0.
- rst asserted while a request is pending with no ack → next cycle imem_req=0, if_id_valid=0; after release the first req addr is RESET_PC.
